// File: rtl/hack_pkg.sv
// Shared definitions for the second-generation Hack computer: controller state
// encoding, the canonical end-loop instruction and the default word width.
package hack_pkg;

    localparam int DATA_W_DEFAULT = 16;

    // 0;JMP -- paired with an @N that points back at itself (or at the @N) it forms the end loop
    localparam logic [15:0] HALT_INSTR = 16'hEA87;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_HALT = 2'b11
    } state_t;

endpackage

// File: rtl/hack_cpu.sv
// Hack CPU with clock enable and a synchronous CPU-only reset; exposes pc_next for the
// registered program fetch.
module hack_cpu #(
    parameter int DATA_W  = 16,
    parameter int PROG_AW = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_rst,
    input  logic               ce,
    input  logic [DATA_W-1:0]  instr,
    input  logic [DATA_W-1:0]  in_m,
    output logic [DATA_W-1:0]  out_m,
    output logic               write_m,
    output logic [DATA_W-2:0]  address_m,
    output logic [PROG_AW-1:0] pc,
    output logic [PROG_AW-1:0] pc_next
);

    logic [DATA_W-1:0]  a_reg, d_reg, x, y, alu_out;
    logic [PROG_AW-1:0] pc_reg;
    logic               is_c, zr, ng, jump;

    assign is_c = instr[DATA_W-1];

    always_comb begin
        x = d_reg;
        y = instr[12] ? in_m : a_reg;
        if (instr[11]) x = '0;
        if (instr[10]) x = ~x;
        if (instr[9])  y = '0;
        if (instr[8])  y = ~y;
        alu_out = instr[7] ? x + y : x & y;
        if (instr[6])  alu_out = ~alu_out;
    end

    assign zr        = (alu_out == '0);
    assign ng        = alu_out[DATA_W-1];
    assign jump      = is_c & ((instr[2] & ng) | (instr[1] & zr) | (instr[0] & ~ng & ~zr));
    assign out_m     = alu_out;
    assign write_m   = ce & is_c & instr[3];
    assign address_m = a_reg[DATA_W-2:0];
    assign pc        = pc_reg;

    always_comb begin
        if (cpu_rst)   pc_next = '0;
        else if (!ce)  pc_next = pc_reg;
        else if (jump) pc_next = a_reg[PROG_AW-1:0];
        else           pc_next = pc_reg + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_reg  <= '0;
            d_reg  <= '0;
            pc_reg <= '0;
        end else if (cpu_rst) begin
            a_reg  <= '0;
            d_reg  <= '0;
            pc_reg <= '0;
        end else if (ce) begin
            if (!is_c)         a_reg <= instr;
            else if (instr[5]) a_reg <= alu_out;
            if (is_c && instr[4]) d_reg <= alu_out;
            pc_reg <= pc_next;
        end
    end

endmodule

// File: rtl/hack_memory.sv
// Hack data memory: synchronous write, combinational read so the CPU sees M in the same cycle.
module hack_memory #(
    parameter int DATA_W = 16,
    parameter int AW     = 15
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**AW];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/prog_ram.sv
// Program store: one synchronous write port (loader) and one registered read port (fetch).
module prog_ram #(
    parameter int DATA_W = 16,
    parameter int AW     = 15
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/hack_computer_v2.sv
// Hack computer top: loadable program RAM, CPU, data memory and the
// load/run/step/halt execution controller.
module hack_computer_v2
    import hack_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int PROG_AW = 15,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_en,
    input  logic               prog_valid,
    output logic               prog_ready,
    input  logic [DATA_W-1:0]  prog_data,
    input  logic               prog_last,
    input  logic               run,
    input  logic               step,
    input  logic               restart,
    output logic [1:0]         state,
    output logic               halted,
    output logic               load_err,
    output logic [PROG_AW-1:0] pc,
    output logic [CNT_W-1:0]   icount
);

    state_t               state_reg;
    logic [PROG_AW-1:0]   load_addr_reg, pc_next, pc_prev;
    logic                 halted_reg, load_err_reg;
    logic [CNT_W-1:0]     icount_reg;
    logic                 cpu_ce, cpu_rst, prog_we, write_m, halt_hit;
    logic [DATA_W-1:0]    instr, in_m, out_m;
    logic [DATA_W-2:0]    address_m;

    assign prog_ready = (state_reg == ST_LOAD);
    assign prog_we    = prog_valid && prog_ready;
    assign state      = state_reg;
    assign halted     = halted_reg;
    assign load_err   = load_err_reg;
    assign icount     = icount_reg;
    assign pc_prev    = pc - 1'b1;

    always_comb begin
        cpu_ce  = 1'b0;
        cpu_rst = 1'b0;
        if (restart) begin
            cpu_rst = 1'b1;
        end else begin
            case (state_reg)
                ST_LOAD: cpu_rst = 1'b1;
                ST_RUN:  cpu_ce  = 1'b1;
                ST_IDLE: cpu_ce  = !load_en && !run && step;
                ST_HALT: cpu_ce  = !load_en && !(run && !halted_reg) && step;
                default: ;
            endcase
        end
    end

    // A jump to itself or back to its own @N loops forever; both count as the end loop.
    assign halt_hit = cpu_ce && (instr == DATA_W'(HALT_INSTR)) &&
                      ((address_m == (DATA_W-1)'(pc)) || (address_m == (DATA_W-1)'(pc_prev)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            load_addr_reg <= '0;
            halted_reg    <= 1'b0;
            load_err_reg  <= 1'b0;
            icount_reg    <= '0;
        end else begin
            if (cpu_ce && icount_reg != '1) icount_reg <= icount_reg + 1'b1;
            if (prog_we) begin
                load_addr_reg <= load_addr_reg + 1'b1;
                if (load_addr_reg == '1) load_err_reg <= 1'b1;
            end
            if (restart) begin
                icount_reg <= '0;
                halted_reg <= 1'b0;
                state_reg  <= ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (load_en) begin
                            state_reg     <= ST_LOAD;
                            load_addr_reg <= '0;
                        end else if (run) begin
                            state_reg <= ST_RUN;
                        end else if (step) begin
                            state_reg <= ST_HALT;
                            if (halt_hit) halted_reg <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        if (!load_en || (prog_valid && prog_last)) state_reg <= ST_IDLE;
                    end
                    ST_RUN: begin
                        if (halt_hit) begin
                            halted_reg <= 1'b1;
                            state_reg  <= ST_HALT;
                        end else if (!run) begin
                            state_reg <= ST_HALT;
                        end
                    end
                    ST_HALT: begin
                        if (load_en) begin
                            state_reg     <= ST_LOAD;
                            load_addr_reg <= '0;
                        end else if (run && !halted_reg) begin
                            state_reg <= ST_RUN;
                        end else if (step && halt_hit) begin
                            halted_reg <= 1'b1;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    prog_ram #(.DATA_W(DATA_W), .AW(PROG_AW)) u_prog (
        .clk   (clk),
        .we    (prog_we),
        .waddr (load_addr_reg),
        .wdata (prog_data),
        .raddr (pc_next),
        .rdata (instr)
    );

    hack_cpu #(.DATA_W(DATA_W), .PROG_AW(PROG_AW)) u_cpu (
        .clk       (clk),
        .reset     (reset),
        .cpu_rst   (cpu_rst),
        .ce        (cpu_ce),
        .instr     (instr),
        .in_m      (in_m),
        .out_m     (out_m),
        .write_m   (write_m),
        .address_m (address_m),
        .pc        (pc),
        .pc_next   (pc_next)
    );

    hack_memory #(.DATA_W(DATA_W), .AW(DATA_W-1)) u_mem (
        .clk   (clk),
        .we    (write_m),
        .addr  (address_m),
        .wdata (out_m),
        .rdata (in_m)
    );

endmodule
